// File: rtl/i2s_receive.sv
// i2s_receive: I2S serial audio receiver with an AXI-Stream master output.
// sck/ws/sd are synchronized into M_AXIS_ACLK, words are collected MSB first
// and closed on each ws change, then queued in a small {TLAST, TDATA} FIFO.
// Left/right pairing is kept intact: a right word whose left partner was
// lost (start-up discard or FIFO overflow) is dropped as well.
// Optional feature: define I2S_RX_OVERFLOW_CNT_EN to add the 16-bit
// saturating overflow_count output.
module i2s_receive #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         M_AXIS_ACLK,
    input  logic                         M_AXIS_ARESET,
    input  logic                         sck,
    input  logic                         ws,
    input  logic                         sd,
    output logic signed [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                         M_AXIS_TVALID,
    input  logic                         M_AXIS_TREADY,
    output logic                         M_AXIS_TLAST,
    output logic                         overflow
`ifdef I2S_RX_OVERFLOW_CNT_EN
    ,
    output logic [15:0]                  overflow_count
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int ENT_W = DATA_WIDTH + 1;

    localparam logic [0:0]       ST_SYNC = 1'b0;
    localparam logic [0:0]       ST_RUN  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH);

    // Bit counter advances until it reaches DATA_WIDTH and then holds there.
    function automatic logic [CNT_W-1:0] bit_cnt_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 1'b1;
    endfunction

    // Places bit b at position DATA_WIDTH-1-pos; once pos reaches DATA_WIDTH
    // the mask shifts out entirely, so surplus bits are discarded for free.
    function automatic logic signed [DATA_WIDTH-1:0] insert_bit(
        input logic signed [DATA_WIDTH-1:0] word,
        input logic        [CNT_W-1:0]      pos,
        input logic                         b
    );
        logic [DATA_WIDTH-1:0] mask;
        mask                 = '0;
        mask[DATA_WIDTH-1]   = 1'b1;
        mask                 = mask >> pos;
        return b ? (word | $signed(mask)) : word;
    endfunction

    // Synchronizer stages
    logic sck_p0, sck_p1, sck_p2;
    logic ws_p0, ws_p1;
    logic sd_p0, sd_p1;

    // Capture stage
    logic [0:0]                   state;
    logic                         ws_prev;
    logic [CNT_W-1:0]             bit_cnt;
    logic signed [DATA_WIDTH-1:0] shreg;
    logic signed [DATA_WIDTH-1:0] word_nxt;
    logic                         srise;
    logic                         boundary;

    // Closed-word stage
    logic signed [DATA_WIDTH-1:0] word_p0;
    logic                         last_p0;
    logic                         disc_p0;
    logic                         vld_p0;

    // FIFO and pairing control
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic [ENT_W-1:0] head;
    logic             full, empty;
    logic             rd_en, wr_req, wr_en, ovf_drop;
    logic             drop_r;

    // Two-flop synchronizers; sck carries one extra stage for rise detection
    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            sck_p0 <= 1'b0;
            sck_p1 <= 1'b0;
            sck_p2 <= 1'b0;
            ws_p0  <= 1'b0;
            ws_p1  <= 1'b0;
            sd_p0  <= 1'b0;
            sd_p1  <= 1'b0;
        end else begin
            sck_p0 <= sck;
            sck_p1 <= sck_p0;
            sck_p2 <= sck_p1;
            ws_p0  <= ws;
            ws_p1  <= ws_p0;
            sd_p0  <= sd;
            sd_p1  <= sd_p0;
        end
    end

    assign srise    = sck_p1 & ~sck_p2;
    assign boundary = srise & (ws_p1 != ws_prev);
    assign word_nxt = insert_bit(shreg, bit_cnt, sd_p1);

    // ---- stage p0: collect bits, close a word on every ws change ----
    // Shift in on each sck rise; on a boundary the final bit is merged and the word is handed on
    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            state   <= ST_SYNC;
            ws_prev <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
            word_p0 <= '0;
            last_p0 <= 1'b0;
            disc_p0 <= 1'b0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (srise) begin
                ws_prev <= ws_p1;
                if (boundary) begin
                    word_p0 <= word_nxt;
                    last_p0 <= ws_prev;
                    disc_p0 <= (state == ST_SYNC);
                    vld_p0  <= 1'b1;
                    state   <= ST_RUN;
                    shreg   <= '0;
                    bit_cnt <= '0;
                end else begin
                    shreg   <= word_nxt;
                    bit_cnt <= bit_cnt_inc(bit_cnt);
                end
            end
        end
    end

    // ---- stage p1: FIFO write, overflow and pair alignment ----
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rd_en  = ~empty & M_AXIS_TREADY;
    assign wr_req = vld_p0 & ~disc_p0 & ~(drop_r & last_p0);
    assign wr_en  = wr_req & (~full | rd_en);
    assign ovf_drop = wr_req & full & ~rd_en;

    // Pointer, sticky overflow and orphan-right suppression bookkeeping
    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            drop_r   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ovf_drop) begin
                overflow <= 1'b1;
            end
            if (vld_p0) begin
                if (disc_p0) begin
                    // A discarded start-up left word leaves its right partner orphaned
                    drop_r <= ~last_p0;
                end else begin
                    drop_r <= ovf_drop & ~last_p0;
                end
            end
        end
    end

    // FIFO storage holds {TLAST, TDATA}; data only, so no reset
    always_ff @(posedge M_AXIS_ACLK) begin
        if (wr_en) begin
            mem[wr_ptr[PTR_W-1:0]] <= {last_p0, word_p0};
        end
    end

    // Head of the FIFO drives the stream directly, forced to zero when empty
    assign head          = mem[rd_ptr[PTR_W-1:0]];
    assign M_AXIS_TVALID = ~empty;
    assign M_AXIS_TLAST  = ~empty & head[DATA_WIDTH];
    assign M_AXIS_TDATA  = empty ? '0 : $signed(head[DATA_WIDTH-1:0]);

`ifdef I2S_RX_OVERFLOW_CNT_EN
    logic        drop_ovf;
    logic [15:0] ovf_cnt;

    function automatic logic [15:0] ovf_cnt_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Remembers whether the pending right-word drop was caused by an overflow
    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            drop_ovf <= 1'b0;
        end else if (vld_p0) begin
            drop_ovf <= ~disc_p0 & ovf_drop & ~last_p0;
        end
    end

    // Counts every word lost to overflow, including the paired right word
    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            ovf_cnt <= '0;
        end else if (ovf_drop || (vld_p0 && !disc_p0 && drop_r && last_p0 && drop_ovf)) begin
            ovf_cnt <= ovf_cnt_inc(ovf_cnt);
        end
    end

    assign overflow_count = ovf_cnt;
`endif

endmodule
